// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue front end.
// Op codes, FSM state type and the expected-value model.
package alu_pkg;

    localparam int OP_W   = 3;
    localparam int DATA_W = 32;

    localparam logic [OP_W-1:0] OP_ADD = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB = 3'd1;
    localparam logic [OP_W-1:0] OP_AND = 3'd2;
    localparam logic [OP_W-1:0] OP_OR  = 3'd3;
    localparam logic [OP_W-1:0] OP_SRL = 3'd4;
    localparam logic [OP_W-1:0] OP_SRA = 3'd5;

    typedef enum logic {
        IDLE,
        EXEC
    } state_t;

    // Expected ALU result; illegal codes yield zero.
    function automatic logic [DATA_W-1:0] alu_ref(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic [OP_W-1:0]   op
    );
        logic [DATA_W-1:0] r;
        r = '0;
        case (op)
            OP_ADD: r = a + b;
            OP_SUB: r = a - b;
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_SRL: r = a >> b[4:0];
            OP_SRA: r = DATA_W'($signed(a) >>> b[4:0]);
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_result_fifo.sv
// Circular result buffer, DEPTH entries of WIDTH bits.
// Pops on an empty buffer are ignored.
module alu_result_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_pop;

    assign do_pop = pop && (count != '0);
    assign head   = mem[rd_ptr];

    // Storage, power-of-two pointers wrap naturally, occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_unit.sv
// Flow-controlled requester in front of the combinational alu.
// Optional ALU_CHECK_EN adds a sticky reference-model check.
module alu_issue_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [OP_W-1:0]  in_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OP_W-1:0]  alu_op,
    input  logic [WIDTH-1:0] alu_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_c,
    output logic [OP_W-1:0]  out_op,
    output logic             out_err,
    output logic [CNT_W-1:0] op_count,
    output logic             mismatch
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = WIDTH + OP_W + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   count;
    logic            accept;
    logic            push;
    logic            legal;
    logic [EW-1:0]   push_data;
    logic [EW-1:0]   head;

    assign accept = in_valid && in_ready;
    assign legal  = (alu_op <= OP_SRA);

    assign push_data = {~legal, alu_op,
                        legal ? alu_c : {WIDTH{1'b0}}};

    assign out_valid = (count != '0);
    assign out_err   = head[EW-1];
    assign out_op    = head[WIDTH +: OP_W];
    assign out_c     = head[WIDTH-1:0];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state, request handshake and buffer push.
    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        push     = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = (count < FULL);
                if (in_valid && (count < FULL)) begin
                    state_nx = EXEC;
                end
            end
            EXEC: begin
                push     = 1'b1;
                state_nx = IDLE;
            end
        endcase
    end

    // ALU operand registers change only on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= '0;
        end else if (accept) begin
            alu_a  <= in_a;
            alu_b  <= in_b;
            alu_op <= in_op;
        end
    end

    // Completed-operation counter, wraps at full scale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (push) begin
            op_count <= op_count + 1'b1;
        end
    end

    alu_result_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (out_ready),
        .head      (head),
        .count     (count)
    );

`ifdef ALU_CHECK_EN
    logic [WIDTH-1:0] expect_c;

    assign expect_c = WIDTH'(alu_ref(DATA_W'(alu_a),
                                     DATA_W'(alu_b),
                                     alu_op));

    // Sticky flag on any legal-op disagreement at capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch <= 1'b0;
        end else if (state == EXEC && legal
                     && alu_c != expect_c) begin
            mismatch <= 1'b1;
        end
    end
`else
    assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: directed and random requests
// scored against a queue of expected results.
module tb_alu_issue_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [2:0]  in_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic [31:0] alu_c;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_c;
    logic [2:0]  out_op;
    logic        out_err;
    logic [15:0] op_count;
    logic        mismatch;
    logic        corrupt;

    typedef struct {
        logic [31:0] c;
        logic [2:0]  op;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    int          cmp_cnt = 0;
    int          bad_cnt = 0;
    int          tb_cnt  = 0;
    bit          rnd_mode = 0;
    bit          hold_v = 0;
    logic [31:0] hold_c;
    logic [2:0]  hold_op;
    logic        hold_err;

    always #5 clk = ~clk;

    function automatic logic [31:0] golden(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [2:0]  op
    );
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a >> b[4:0];
            3'd5: return 32'($signed(a) >>> b[4:0]);
            default: return 32'hdeadbeef;
        endcase
    endfunction

    // Environment ALU; corrupt flips bit 0 to provoke the checker.
    assign alu_c = corrupt ? golden(alu_a, alu_b, alu_op) ^ 32'h1
                           : golden(alu_a, alu_b, alu_op);

    alu_issue_unit #(
        .WIDTH (32),
        .DEPTH (2),
        .CNT_W (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_c     (alu_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_c     (out_c),
        .out_op    (out_op),
        .out_err   (out_err),
        .op_count  (op_count),
        .mismatch  (mismatch)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            bad_cnt++;
            $error("FAIL %s: observed %h expected %h",
                   tag, obs, exp);
        end
    endtask

    // One clock: score pops and head stability at negedge.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        if (hold_v && out_valid) begin
            chk("hold_c", out_c, hold_c);
            chk("hold_op", 32'(out_op), 32'(hold_op));
            chk("hold_err", 32'(out_err), 32'(hold_err));
        end
        hold_v   = out_valid && !out_ready;
        hold_c   = out_c;
        hold_op  = out_op;
        hold_err = out_err;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_pop", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("out_c", out_c, e.c);
                chk("out_op", 32'(out_op), 32'(e.op));
                chk("out_err", 32'(out_err), 32'(e.err));
            end
        end
        @(posedge clk);
        #1;
        if (rnd_mode) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [2:0]  op);
        int   n;
        exp_t e;
        n        = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_op    = op;
        while (!in_ready && n < 200) begin
            cycle();
            n++;
        end
        chk("accept_timeout", 32'(n < 200), 32'd1);
        if (n < 200) begin
            e.err = (op > 3'd5);
            e.op  = op;
            if (e.err)        e.c = 32'h0;
            else if (corrupt) e.c = golden(a, b, op) ^ 32'h1;
            else              e.c = golden(a, b, op);
            exp_q.push_back(e);
            tb_cnt++;
            cycle();
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            cycle();
            n++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = '0;
        out_ready = 1'b1;
        corrupt   = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_alu_a", alu_a, 32'h0);
        chk("rst_alu_b", alu_b, 32'h0);
        chk("rst_alu_op", 32'(alu_op), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_c", out_c, 32'h0);
        chk("rst_out_op", 32'(out_op), 32'h0);
        chk("rst_out_err", 32'(out_err), 32'h0);
        chk("rst_op_count", 32'(op_count), 32'h0);
        chk("rst_mismatch", 32'(mismatch), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'h1);

        for (int op = 0; op < 6; op++) begin
            send(32'h0000f001, 32'h4, 3'(op));
        end
        drain();
        chk("count_six", 32'(op_count), 32'd6);

        send(32'h80000000, 32'h4, 3'd5);
        send(32'h80000000, 32'h4, 3'd4);
        drain();

        out_ready = 1'b0;
        send(32'h1, 32'h1, 3'd0);
        send(32'h1, 32'h2, 3'd0);
        cycle();
        cycle();
        chk("bp_in_ready", 32'(in_ready), 32'h0);
        chk("bp_out_valid", 32'(out_valid), 32'h1);
        chk("bp_head", out_c, 32'h2);
        out_ready = 1'b1;
        send(32'h2, 32'h2, 3'd0);
        drain();

        send(32'h5, 32'h3, 3'd7);
        drain();
        chk("illegal_count", 32'(op_count), 32'(tb_cnt));
        chk("illegal_mismatch", 32'(mismatch), 32'h0);

        send(32'hffffffff, 32'h1, 3'd0);
        send(32'h0, 32'h1, 3'd1);
        drain();

        rnd_mode = 1;
        for (int i = 0; i < 60; i++) begin
            send($urandom, $urandom, 3'($urandom_range(0, 7)));
        end
        drain();
        rnd_mode  = 0;
        out_ready = 1'b1;
        chk("rand_count", 32'(op_count), 32'(tb_cnt & 16'hffff));

`ifdef ALU_CHECK_EN
        corrupt = 1'b1;
        send(32'h3, 32'h4, 3'd0);
        cycle();
        corrupt = 1'b0;
        send(32'h7, 32'h1, 3'd3);
        drain();
        chk("mismatch_set", 32'(mismatch), 32'h1);
`else
        chk("mismatch_off", 32'(mismatch), 32'h0);
`endif

        out_ready = 1'b0;
        send(32'h1, 32'h2, 3'd0);
        send(32'h3, 32'h4, 3'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_out_valid", 32'(out_valid), 32'h0);
        chk("mid_op_count", 32'(op_count), 32'h0);
        chk("mid_alu_a", alu_a, 32'h0);
        chk("mid_alu_b", alu_b, 32'h0);
        chk("mid_alu_op", 32'(alu_op), 32'h0);
        chk("mid_mismatch", 32'(mismatch), 32'h0);
        exp_q.delete();
        hold_v = 0;
        tb_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(32'h10, 32'h20, 3'd3);
        drain();
        chk("post_rst_count", 32'(op_count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 cmp_cnt, bad_cnt);
        $finish;
    end

endmodule
